// File: rtl/controladora_pkg.sv
// ============================================================================
// controladora_pkg : opcode map, FSM/class encodings and mux select codes
// Rev 1.0
// ============================================================================
`default_nettype none

package controladora_pkg;

  localparam logic [4:0] OP_ADD     = 5'b00001;
  localparam logic [4:0] OP_ADDI    = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011;
  localparam logic [4:0] OP_SUBI    = 5'b00100;
  localparam logic [4:0] OP_LOAD    = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b00110;
  localparam logic [4:0] OP_IN      = 5'b00111;
  localparam logic [4:0] OP_OUT     = 5'b01000;
  localparam logic [4:0] OP_JUMP    = 5'b01001;
  localparam logic [4:0] OP_JUMPI   = 5'b01010;
  localparam logic [4:0] OP_BRANCH  = 5'b01011;
  localparam logic [4:0] OP_BRANCHI = 5'b01100;
  localparam logic [4:0] OP_LOADI   = 5'b01101;
  localparam logic [4:0] OP_MORE    = 5'b01110;
  localparam logic [4:0] OP_LESS    = 5'b01111;
  localparam logic [4:0] OP_EQUAL   = 5'b10000;
  localparam logic [4:0] OP_STOP    = 5'b11111;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_IO_IN  = 3'd5,
    ST_IO_OUT = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_LOADI   = 4'd3,
    CLS_IN      = 4'd4,
    CLS_OUT     = 4'd5,
    CLS_JUMP    = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_STOP    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } cls_t;

  typedef enum logic [2:0] {
    ULA_ADD   = 3'b000,
    ULA_SUB   = 3'b001,
    ULA_MORE  = 3'b010,
    ULA_LESS  = 3'b011,
    ULA_EQUAL = 3'b100
  } ula_e;

  typedef enum logic [1:0] {
    WB_IN  = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10,
    WB_IMM = 2'b11
  } wb_e;

  typedef enum logic [1:0] {
    OPB_REG = 2'b00,
    OPB_IMM = 2'b01
  } opb_e;

  typedef enum logic [1:0] {
    JT_IMM  = 2'b00,
    JT_REG  = 2'b01,
    JT_BREG = 2'b10
  } jt_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_TGT = 2'b01,
    PC_REG = 2'b10
  } pc_e;

endpackage

`default_nettype wire

// File: rtl/controladora_decode.sv
// ============================================================================
// controladora_decode : opcode -> instruction class, ALU op and static selects
// Rev 1.0
// ============================================================================
`default_nettype none

module controladora_decode
  import controladora_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output cls_t                cls,
  output logic [2:0]          ula_op,
  output logic [1:0]          sel_wb,
  output logic [1:0]          sel_opb,
  output logic [1:0]          sel_jt
);

  // Any opcode bit above the 5-bit map makes the instruction illegal.
  logic [31:0] w_op_ext;
  logic        w_hi_zero;

  assign w_op_ext  = 32'(opcode);
  assign w_hi_zero = (w_op_ext[31:5] == 27'd0);

  always_comb begin
    cls     = CLS_ILLEGAL;
    ula_op  = ULA_ADD;
    sel_wb  = WB_IN;
    sel_opb = OPB_REG;
    sel_jt  = JT_IMM;
    if (w_hi_zero) begin
      case (w_op_ext[4:0])
        OP_ADD:     begin cls = CLS_ALU; sel_wb = WB_ALU; end
        OP_ADDI:    begin cls = CLS_ALU; sel_wb = WB_ALU; sel_opb = OPB_IMM; end
        OP_SUB:     begin cls = CLS_ALU; sel_wb = WB_ALU; ula_op = ULA_SUB; end
        OP_SUBI:    begin cls = CLS_ALU; sel_wb = WB_ALU; ula_op = ULA_SUB; sel_opb = OPB_IMM; end
        OP_MORE:    begin cls = CLS_ALU; sel_wb = WB_ALU; ula_op = ULA_MORE; end
        OP_LESS:    begin cls = CLS_ALU; sel_wb = WB_ALU; ula_op = ULA_LESS; end
        OP_EQUAL:   begin cls = CLS_ALU; sel_wb = WB_ALU; ula_op = ULA_EQUAL; end
        OP_LOAD:    begin cls = CLS_LOAD; sel_wb = WB_MEM; end
        OP_STORE:   cls = CLS_STORE;
        OP_LOADI:   begin cls = CLS_LOADI; sel_wb = WB_IMM; end
        OP_IN:      cls = CLS_IN;
        OP_OUT:     cls = CLS_OUT;
        OP_JUMP:    begin cls = CLS_JUMP; sel_jt = JT_REG; end
        OP_JUMPI:   cls = CLS_JUMP;
        OP_BRANCH:  begin cls = CLS_BRANCH; sel_jt = JT_BREG; end
        OP_BRANCHI: cls = CLS_BRANCH;
        OP_STOP:    cls = CLS_STOP;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/controladora_multiciclo.sv
// ============================================================================
// controladora_multiciclo : multi-cycle control FSM with memory latency and I/O handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

module controladora_multiciclo
  import controladora_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   reg_branch,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic                ir_load,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic [1:0]          sel_mult01,
  output logic [1:0]          sel_mult02,
  output logic [1:0]          sel_mult03,
  output logic                mem_we,
  output logic [2:0]          ula_op,
  output logic                disp_out,
  output logic                in_ack,
  output logic                halted,
  output logic                illegal
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cls_t              cls_q, cls_d;
  logic [2:0]        ula_q, ula_d;
  logic [1:0]        wb_q, wb_d;
  logic [1:0]        opb_q, opb_d;
  logic [1:0]        jt_q, jt_d;

  cls_t              w_cls;
  logic [2:0]        w_dec_ula;
  logic [1:0]        w_dec_wb, w_dec_opb, w_dec_jt;
  logic              w_last, w_taken;

  logic              w_ir_load, w_pc_en, w_reg_we, w_mem_we;
  logic              w_disp, w_in_ack, w_halted, w_illegal;
  logic [1:0]        w_pc_sel, w_sel01, w_sel02, w_sel03;
  logic [2:0]        w_ula;

  controladora_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode  (opcode),
    .cls     (w_cls),
    .ula_op  (w_dec_ula),
    .sel_wb  (w_dec_wb),
    .sel_opb (w_dec_opb),
    .sel_jt  (w_dec_jt)
  );

  assign w_last  = (cnt_q == LAT_LAST);
  assign w_taken = (reg_branch == DATA_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    ula_d     = ula_q;
    wb_d      = wb_q;
    opb_d     = opb_q;
    jt_d      = jt_q;
    w_ir_load = 1'b0;
    w_pc_en   = 1'b0;
    w_pc_sel  = PC_INC;
    w_reg_we  = 1'b0;
    w_sel01   = 2'b00;
    w_sel02   = 2'b00;
    w_sel03   = 2'b00;
    w_mem_we  = 1'b0;
    w_ula     = ULA_ADD;
    w_disp    = 1'b0;
    w_in_ack  = 1'b0;
    w_halted  = 1'b0;
    w_illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        w_ir_load = (cnt_q == '0);
        if (w_last) begin
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d = w_cls;
        ula_d = w_dec_ula;
        wb_d  = w_dec_wb;
        opb_d = w_dec_opb;
        jt_d  = w_dec_jt;
        case (w_cls)
          CLS_ALU, CLS_JUMP, CLS_BRANCH: state_d = ST_EXEC;
          CLS_LOAD, CLS_STORE:           state_d = ST_MEM;
          CLS_LOADI:                     state_d = ST_WB;
          CLS_IN:                        state_d = ST_IO_IN;
          CLS_OUT:                       state_d = ST_IO_OUT;
          CLS_STOP:                      state_d = ST_HALT;
          default: begin
            w_illegal = 1'b1;
            w_pc_en   = 1'b1;
            w_pc_sel  = PC_INC;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_JUMP: begin
            w_pc_en  = 1'b1;
            w_pc_sel = PC_TGT;
            w_sel03  = jt_q;
            state_d  = ST_FETCH;
          end
          CLS_BRANCH: begin
            w_pc_en  = 1'b1;
            w_pc_sel = w_taken ? PC_TGT : PC_INC;
            w_sel03  = jt_q;
            state_d  = ST_FETCH;
          end
          default: begin
            w_ula   = ula_q;
            w_sel02 = opb_q;
            state_d = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        if (cls_q == CLS_STORE) begin
          w_mem_we = (cnt_q == '0);
          w_pc_en  = w_last;
        end
        if (w_last) begin
          cnt_d   = '0;
          state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        w_reg_we = 1'b1;
        w_sel01  = wb_q;
        w_pc_en  = 1'b1;
        w_pc_sel = PC_INC;
        // ALU result is written this cycle, so its operands must stay selected.
        if (cls_q == CLS_ALU) begin
          w_ula   = ula_q;
          w_sel02 = opb_q;
        end
        state_d = ST_FETCH;
      end
      ST_IO_IN: begin
        if (in_valid) begin
          w_in_ack = 1'b1;
          state_d  = ST_WB;
        end
      end
      ST_IO_OUT: begin
        w_disp  = 1'b1;
        w_sel02 = OPB_REG;
        if (out_ready) begin
          w_pc_en = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: w_halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      cls_q   <= CLS_ILLEGAL;
      ula_q   <= 3'b000;
      wb_q    <= 2'b00;
      opb_q   <= 2'b00;
      jt_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      ula_q   <= ula_d;
      wb_q    <= wb_d;
      opb_q   <= opb_d;
      jt_q    <= jt_d;
    end
  end

  // Reset parks the FSM in FETCH, where ir_load is the only output that could be high.
  assign ir_load    = w_ir_load & reset_n;
  assign pc_en      = w_pc_en;
  assign pc_sel     = w_pc_sel;
  assign reg_we     = w_reg_we;
  assign sel_mult01 = w_sel01;
  assign sel_mult02 = w_sel02;
  assign sel_mult03 = w_sel03;
  assign mem_we     = w_mem_we;
  assign ula_op     = w_ula;
  assign disp_out   = w_disp;
  assign in_ack     = w_in_ack;
  assign halted     = w_halted;
  assign illegal    = w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_controladora_multiciclo.sv
// ============================================================================
// tb_controladora_multiciclo : per-cycle timeline model of each instruction
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_controladora_multiciclo;

  localparam int L = 3;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_LOADI = 3, K_IN = 4;
  localparam int K_OUT = 5, K_JUMP = 6, K_BR = 7, K_STOP = 8, K_ILL = 9;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] s3;
    logic       mem_we;
    logic [2:0] ula;
    logic       disp;
    logic       in_ack;
    logic       halted;
    logic       illegal;
  } ov_t;

  typedef struct {
    ov_t         e;
    logic        iv;
    logic        orr;
    logic [31:0] rb;
  } cyc_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] reg_branch = 32'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        ir_load, pc_en, reg_we, mem_we, disp_out, in_ack, halted, illegal;
  logic [1:0]  pc_sel, sel_mult01, sel_mult02, sel_mult03;
  logic [2:0]  ula_op;

  int    checks = 0;
  int    errors = 0;
  string tag = "reset";
  cyc_t  tr[$];
  logic [4:0] legal_ops[16] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                                5'b01101, 5'b01110, 5'b01111, 5'b10000};

  controladora_multiciclo #(
    .OPCODE_W (5),
    .DATA_W   (32),
    .MEM_LAT  (L)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .reg_branch (reg_branch),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .reg_we     (reg_we),
    .sel_mult01 (sel_mult01),
    .sel_mult02 (sel_mult02),
    .sel_mult03 (sel_mult03),
    .mem_we     (mem_we),
    .ula_op     (ula_op),
    .disp_out   (disp_out),
    .in_ack     (in_ack),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  function automatic ov_t observed();
    ov_t o;
    o.ir_load = ir_load;    o.pc_en  = pc_en;      o.pc_sel = pc_sel;
    o.reg_we  = reg_we;     o.s1     = sel_mult01; o.s2     = sel_mult02;
    o.s3      = sel_mult03; o.mem_we = mem_we;     o.ula    = ula_op;
    o.disp    = disp_out;   o.in_ack = in_ack;     o.halted = halted;
    o.illegal = illegal;
    return o;
  endfunction

  task automatic chk(input string name, input ov_t exp);
    ov_t o;
    o = observed();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, o, exp);
    end
  endtask

  function automatic logic [31:0] rnd_rb();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic int kind(input logic [4:0] op);
    case (op)
      5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b01110, 5'b01111, 5'b10000: return K_ALU;
      5'b00101: return K_LOAD;
      5'b00110: return K_STORE;
      5'b01101: return K_LOADI;
      5'b00111: return K_IN;
      5'b01000: return K_OUT;
      5'b01001, 5'b01010: return K_JUMP;
      5'b01011, 5'b01100: return K_BR;
      5'b11111: return K_STOP;
      default:  return K_ILL;
    endcase
  endfunction

  // {ula_op, operand-B select} for each ALU instruction
  function automatic logic [4:0] alu_fields(input logic [4:0] op);
    case (op)
      5'b00010: return {3'b000, 2'b01};
      5'b00011: return {3'b001, 2'b00};
      5'b00100: return {3'b001, 2'b01};
      5'b01110: return {3'b010, 2'b00};
      5'b01111: return {3'b011, 2'b00};
      5'b10000: return {3'b100, 2'b00};
      default:  return {3'b000, 2'b00};
    endcase
  endfunction

  task automatic push(input ov_t e, input logic iv, input logic orr, input logic [31:0] rb);
    cyc_t c;
    c.e = e; c.iv = iv; c.orr = orr; c.rb = rb;
    tr.push_back(c);
  endtask

  task automatic push_r(input ov_t e);
    push(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_rb());
  endtask

  // Expected output timeline of one instruction, with the inputs to apply each cycle.
  task automatic build(input logic [4:0] op, input logic [31:0] rb, input int nwait, input int nhalt);
    ov_t        e;
    int         k;
    logic [4:0] af;
    tr.delete();
    k = kind(op);
    for (int i = 0; i < L; i++) begin
      e = '0; e.ir_load = (i == 0); push_r(e);
    end
    e = '0;
    if (k == K_ILL) begin
      e.illegal = 1'b1; e.pc_en = 1'b1; push_r(e);
      return;
    end
    push_r(e);
    case (k)
      K_ALU: begin
        af = alu_fields(op);
        e.ula = af[4:2]; e.s2 = af[1:0]; push_r(e);
        e.reg_we = 1'b1; e.s1 = 2'b01; e.pc_en = 1'b1; push_r(e);
      end
      K_JUMP: begin
        e.pc_en = 1'b1; e.pc_sel = 2'b01; e.s3 = (op == 5'b01001) ? 2'b01 : 2'b00; push_r(e);
      end
      K_BR: begin
        e.pc_en = 1'b1;
        e.pc_sel = (rb == 32'd1) ? 2'b01 : 2'b00;
        e.s3 = (op == 5'b01011) ? 2'b10 : 2'b00;
        push(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb);
      end
      K_LOAD: begin
        for (int i = 0; i < L; i++) push_r('0);
        e.reg_we = 1'b1; e.s1 = 2'b10; e.pc_en = 1'b1; push_r(e);
      end
      K_STORE: begin
        for (int i = 0; i < L; i++) begin
          e = '0; e.mem_we = (i == 0); e.pc_en = (i == L - 1); push_r(e);
        end
      end
      K_LOADI: begin
        e.reg_we = 1'b1; e.s1 = 2'b11; e.pc_en = 1'b1; push_r(e);
      end
      K_IN: begin
        for (int i = 0; i < nwait; i++) push('0, 1'b0, 1'($urandom_range(0, 1)), rnd_rb());
        e.in_ack = 1'b1; push(e, 1'b1, 1'($urandom_range(0, 1)), rnd_rb());
        e = '0; e.reg_we = 1'b1; e.s1 = 2'b00; e.pc_en = 1'b1; push_r(e);
      end
      K_OUT: begin
        e.disp = 1'b1;
        for (int i = 0; i < nwait; i++) push(e, 1'($urandom_range(0, 1)), 1'b0, rnd_rb());
        e.pc_en = 1'b1; push(e, 1'($urandom_range(0, 1)), 1'b1, rnd_rb());
      end
      default: begin
        e.halted = 1'b1;
        for (int i = 0; i < nhalt; i++) push_r(e);
      end
    endcase
  endtask

  task automatic play(input int limit);
    for (int i = 0; i < tr.size() && i < limit; i++) begin
      in_valid   = tr[i].iv;
      out_ready  = tr[i].orr;
      reg_branch = tr[i].rb;
      @(negedge clock);
      chk($sformatf("%s[%0d]", tag, i), tr[i].e);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] rb, input int nwait,
                     input int nhalt, input string name);
    opcode = op;
    tag    = name;
    build(op, rb, nwait, nhalt);
    play(tr.size());
  endtask

  // Reset lands in the first MEM cycle; outputs must clear at once, not at the next edge.
  task automatic abort_in_mem(input logic [4:0] op, input string name);
    opcode = op;
    tag    = name;
    build(op, 32'd0, 0, 0);
    play(L + 1);
    in_valid   = tr[L + 1].iv;
    out_ready  = tr[L + 1].orr;
    reg_branch = tr[L + 1].rb;
    #1;
    chk({name, "_pre"}, tr[L + 1].e);
    reset_n = 1'b0;
    #1;
    chk({name, "_async"}, '0);
    @(negedge clock);
    chk({name, "_held"}, '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] rb;
    int          pick;

    reset_n = 1'b0;
    @(negedge clock);
    chk("reset_a", '0);
    opcode = 5'b00001; in_valid = 1'b1; out_ready = 1'b1; reg_branch = 32'd1;
    @(negedge clock);
    chk("reset_b", '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    run(5'b00001, 32'd0, 0, 0, "add");
    run(5'b00110, 32'd0, 0, 0, "store");
    run(5'b01011, 32'd1, 0, 0, "branch_rb1");
    run(5'b01011, 32'd2, 0, 0, "branch_rb2");
    run(5'b01011, 32'hFFFF_FFFF, 0, 0, "branch_ones");
    run(5'b01100, 32'd1, 0, 0, "branchi_rb1");
    run(5'b01100, 32'd0, 0, 0, "branchi_rb0");
    run(5'b01001, 32'd0, 0, 0, "jump");
    run(5'b01010, 32'd0, 0, 0, "jumpi");
    run(5'b00111, 32'd0, 5, 0, "in_wait5");
    run(5'b01000, 32'd0, 4, 0, "out_wait4");
    run(5'b00111, 32'd0, 0, 0, "in_wait0");
    run(5'b01000, 32'd0, 0, 0, "out_wait0");
    run(5'b01101, 32'd0, 0, 0, "loadi");
    run(5'b00101, 32'd0, 0, 0, "load");
    run(5'b00011, 32'd0, 0, 0, "sub");
    run(5'b00100, 32'd0, 0, 0, "subi");
    run(5'b00010, 32'd0, 0, 0, "addi");
    run(5'b01110, 32'd0, 0, 0, "more");
    run(5'b01111, 32'd0, 0, 0, "less");
    run(5'b10000, 32'd0, 0, 0, "equal");
    run(5'b10101, 32'd0, 0, 0, "unknown_10101");
    run(5'b00000, 32'd0, 0, 0, "unknown_00000");

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 19);
      if (pick < 16) op = legal_ops[pick];
      else           op = 5'($urandom_range(0, 31));
      if (op == 5'b11111) op = 5'b10101;
      rb = ($urandom_range(0, 1) == 1) ? 32'd1 : rnd_rb();
      run(op, rb, $urandom_range(0, 3), 0, $sformatf("rand%0d_op%b", n, op));
    end

    abort_in_mem(5'b00101, "abort_load");
    run(5'b00001, 32'd0, 0, 0, "after_abort_load");
    abort_in_mem(5'b00110, "abort_store");
    run(5'b01101, 32'd0, 0, 0, "after_abort_store");

    run(5'b11111, 32'd0, 0, 8, "stop");
    reset_n = 1'b0;
    #1;
    chk("halt_reset", '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run(5'b00001, 32'd0, 0, 0, "after_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
